// File: rtl/vga_mode_sequencer_if.sv
// Signal bundle between vga_mode_sequencer and the video pipeline / user I/O.
// The master side is the sequencer itself; the slave side feeds it and consumes its outputs.
interface vga_mode_sequencer_if;
    logic        vga_vsync;
    logic        vga_active;
    logic        btn_next;
    logic        hold;
    logic [2:0]  mode_sel;
    logic        mode_bit;
    logic        mode_change;
    logic [15:0] frame_cnt;
    logic [31:0] random_num;

    modport master (
        input  vga_vsync,
        input  vga_active,
        input  btn_next,
        input  hold,
        output mode_sel,
        output mode_bit,
        output mode_change,
        output frame_cnt,
        output random_num
    );

    modport slave (
        output vga_vsync,
        output vga_active,
        output btn_next,
        output hold,
        input  mode_sel,
        input  mode_bit,
        input  mode_change,
        input  frame_cnt,
        input  random_num
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous demo mode scheduler: dwell timer plus debounced button advance,
// with mode changes committed only at a blanked frame start. Also a frame counter and LFSR.
module vga_mode_sequencer #(
    parameter int NUM_MODES       = 4,
    parameter int DWELL_FRAMES    = 120,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter bit VS_POL          = 1'b1
) (
    input logic                  clk_dot,
    input logic                  reset,
    vga_mode_sequencer_if.master bus
);

    localparam int              DW         = $clog2(DWELL_FRAMES + 1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [2:0]      MODE_LAST  = 3'(NUM_MODES - 1);
    localparam logic [19:0]     DB_LAST    = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        DEFER = 1'b1
    } state_t;

    logic          vs_q;
    logic          frameStart;
    logic          sync1_q, sync2_q;
    logic          debounced_q, debPrev_q;
    logic [19:0]   dbCnt_q;
    logic          pressEdge;

    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          pending_q, pending_d;
    logic          modeChange_q;
    logic          modeBit_q;
    logic          commit;
    logic          adv;
    logic [15:0]   frameCnt_q;
    logic [31:0]   lfsr_q;

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            vs_q <= ~VS_POL;
        end else begin
            vs_q <= bus.vga_vsync;
        end
    end

    assign frameStart = (bus.vga_vsync == VS_POL) && (vs_q != VS_POL);

    // The debounce counter only runs while the synchronized button disagrees with the accepted level.
    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            debounced_q <= 1'b0;
            debPrev_q   <= 1'b0;
            dbCnt_q     <= '0;
        end else begin
            sync1_q   <= bus.btn_next;
            sync2_q   <= sync1_q;
            debPrev_q <= debounced_q;
            if (sync2_q == debounced_q) begin
                dbCnt_q <= '0;
            end else if (dbCnt_q == DB_LAST) begin
                debounced_q <= sync2_q;
                dbCnt_q     <= '0;
            end else begin
                dbCnt_q <= dbCnt_q + 20'd1;
            end
        end
    end

    assign pressEdge = debounced_q & ~debPrev_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dwell_d   = dwell_q;
        pending_d = pending_q | pressEdge;
        commit    = 1'b0;
        adv       = pending_q | (~bus.hold & (dwell_q == DWELL_LAST));
        unique case (state_q)
            RUN: begin
                if (frameStart) begin
                    if (adv && !bus.vga_active) begin
                        commit = 1'b1;
                    end else if (adv) begin
                        state_d = DEFER;
                    end else if (!bus.hold) begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            DEFER: begin
                if (!bus.vga_active) begin
                    commit  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // A press edge landing on the commit cycle survives and advances at the next frame.
        if (commit) begin
            mode_d    = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
            dwell_d   = '0;
            pending_d = pressEdge;
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            mode_q       <= 3'd0;
            dwell_q      <= '0;
            pending_q    <= 1'b0;
            modeChange_q <= 1'b0;
            modeBit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dwell_q      <= dwell_d;
            pending_q    <= pending_d;
            modeChange_q <= commit;
            modeBit_q    <= (mode_d != 3'd0);
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            frameCnt_q <= 16'h0000;
        end else if (frameStart) begin
            frameCnt_q <= frameCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            lfsr_q <= 32'h0000_0001;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0000_0000);
        end
    end

    assign bus.mode_sel    = mode_q;
    assign bus.mode_bit    = modeBit_q;
    assign bus.mode_change = modeChange_q;
    assign bus.frame_cnt   = frameCnt_q;
    assign bus.random_num  = lfsr_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: directed phases with randomized timing,
// compared against a frame-level model of dwell, button presses and deferred commits.
module tb_vga_mode_sequencer;

    localparam int NM    = 3;
    localparam int DWELL = 3;
    localparam int DB    = 8;

    logic clk_dot = 1'b0;
    logic reset   = 1'b1;

    vga_mode_sequencer_if bus();

    vga_mode_sequencer #(
        .NUM_MODES      (NM),
        .DWELL_FRAMES   (DWELL),
        .DEBOUNCE_CYCLES(DB),
        .VS_POL         (1'b1)
    ) dut (
        .clk_dot(clk_dot),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_dot = ~clk_dot;

    int testsRun    = 0;
    int testsFailed = 0;
    int posCnt      = 0;
    int pulseCnt    = 0;

    int mMode    = 0;
    int mDwell   = 0;
    bit mPending = 1'b0;
    int mFrames  = 0;
    int mPulses  = 0;
    int readyQ[$];

    always @(posedge clk_dot) posCnt <= posCnt + 1;

    // mode_change is read before the edge updates it, so each visible cycle counts once.
    always @(posedge clk_dot) if (bus.mode_change === 1'b1) pulseCnt <= pulseCnt + 1;

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: run exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsrAfter(input int steps);
        logic [31:0] r;
        r = 32'h1;
        for (int i = 0; i < steps; i++) begin
            r = (r >> 1) ^ ((r & 32'h1) != 0 ? 32'h8020_0003 : 32'h0);
        end
        return r;
    endfunction

    // A qualified press becomes visible to frame decisions DB+3 edges after it starts.
    function automatic bit modelFrame();
        bit adv;
        while (readyQ.size() > 0 && readyQ[0] <= posCnt) begin
            void'(readyQ.pop_front());
            mPending = 1'b1;
        end
        mFrames++;
        adv = mPending || (!bus.hold && mDwell >= DWELL - 1);
        if (!adv && !bus.hold) mDwell++;
        return adv;
    endfunction

    function automatic void modelCommit();
        mMode    = (mMode + 1) % NM;
        mDwell   = 0;
        mPending = 1'b0;
        mPulses++;
    endfunction

    task automatic pressButton(input int len);
        if (len >= DB) readyQ.push_back(posCnt + DB + 3);
        fork
            begin
                bus.btn_next = 1'b1;
                repeat (len) @(negedge clk_dot);
                bus.btn_next = 1'b0;
            end
        join_none
    endtask

    task automatic applyStimulus(input bit activeHigh, input int deferLen);
        bit         adv;
        logic [2:0] oldMode;
        oldMode = 3'(mMode);
        adv = modelFrame();
        bus.vga_vsync  = 1'b1;
        bus.vga_active = activeHigh;
        @(negedge clk_dot);
        if (adv && !activeHigh) begin
            modelCommit();
            checkOutput("commit pulse at frame start", 32'(bus.mode_change), 32'd1);
        end else begin
            checkOutput("no pulse at frame start", 32'(bus.mode_change), 32'd0);
        end
        checkOutput("mode after frame start", 32'(bus.mode_sel), 32'(mMode));
        if (adv && activeHigh) begin
            repeat (deferLen) begin
                @(negedge clk_dot);
                checkOutput("mode held while active", 32'(bus.mode_sel), 32'(oldMode));
            end
            bus.vga_active = 1'b0;
            @(negedge clk_dot);
            modelCommit();
            checkOutput("deferred commit pulse", 32'(bus.mode_change), 32'd1);
            checkOutput("deferred commit mode", 32'(bus.mode_sel), 32'(mMode));
            @(negedge clk_dot);
            checkOutput("deferred pulse single", 32'(bus.mode_change), 32'd0);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk_dot);
        bus.vga_vsync  = 1'b0;
        bus.vga_active = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk_dot);
        checkOutput("mode_bit", 32'(bus.mode_bit), (mMode != 0) ? 32'd1 : 32'd0);
        checkOutput("frame_cnt", 32'(bus.frame_cnt), 32'(mFrames & 32'hFFFF));
    endtask

    initial begin
        int         len;
        int         relPos;
        int         savedPulses;
        logic [2:0] modeBefore;

        bus.vga_vsync  = 1'b0;
        bus.vga_active = 1'b0;
        bus.btn_next   = 1'b0;
        bus.hold       = 1'b0;
        reset          = 1'b1;
        repeat (3) @(negedge clk_dot);
        checkOutput("mode in reset", 32'(bus.mode_sel), 32'd0);
        reset  = 1'b0;
        relPos = posCnt;
        checkOutput("lfsr after reset", bus.random_num, 32'h0000_0001);
        checkOutput("mode_bit after reset", 32'(bus.mode_bit), 32'd0);
        checkOutput("mode_change after reset", 32'(bus.mode_change), 32'd0);
        checkOutput("frame_cnt after reset", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk_dot);
        checkOutput("lfsr step 1", bus.random_num, 32'h8020_0003);
        @(negedge clk_dot);
        checkOutput("lfsr step 2", bus.random_num, 32'hC030_0002);

        // Auto dwell: three frames per mode, three modes.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0);
        checkOutput("frames after dwell run", 32'(bus.frame_cnt), 32'd10);
        checkOutput("mode after dwell run", 32'(bus.mode_sel), 32'd0);
        checkOutput("pulses after dwell run", 32'(pulseCnt), 32'd3);

        // Button behaviour with the dwell timer frozen.
        bus.hold = 1'b1;
        len = $urandom_range(1, DB - 1);
        pressButton(len);
        repeat (len + 3 * DB) @(negedge clk_dot);
        applyStimulus(1'b0, 0);
        checkOutput("glitch ignored", 32'(bus.mode_sel), 32'(mMode));

        modeBefore = bus.mode_sel;
        pressButton(20);
        repeat (DB + 2) @(negedge clk_dot);
        applyStimulus(1'b0, 0);
        checkOutput("press not yet pending", 32'(bus.mode_sel), 32'(modeBefore));
        repeat (20 + DB + 6) @(negedge clk_dot);
        len = $urandom_range(DB, 2 * DB);
        pressButton(len);
        repeat (len + 2 * DB + 6) @(negedge clk_dot);
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        checkOutput("two presses one advance", 32'(bus.mode_sel), 32'((modeBefore + 1) % NM));

        modeBefore = bus.mode_sel;
        pressButton(DB + 4);
        repeat (DB + 3) @(negedge clk_dot);
        applyStimulus(1'b0, 0);
        checkOutput("press ready at frame", 32'(bus.mode_sel), 32'((modeBefore + 1) % NM));
        repeat (2 * DB + 6) @(negedge clk_dot);

        modeBefore = bus.mode_sel;
        for (int i = 0; i < 10; i++) applyStimulus(1'($urandom_range(0, 1)), 1);
        checkOutput("hold freezes mode", 32'(bus.mode_sel), 32'(modeBefore));
        pressButton(DB + 2);
        repeat (3 * DB + 6) @(negedge clk_dot);
        applyStimulus(1'b0, 0);
        checkOutput("press under hold", 32'(bus.mode_sel), 32'((modeBefore + 1) % NM));

        // Dwell expiry while held must wait for hold to drop.
        bus.hold = 1'b0;
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        bus.hold = 1'b1;
        modeBefore = bus.mode_sel;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0);
        checkOutput("expiry held", 32'(bus.mode_sel), 32'(modeBefore));
        bus.hold = 1'b0;
        applyStimulus(1'b0, 0);
        checkOutput("expiry after hold", 32'(bus.mode_sel), 32'((modeBefore + 1) % NM));

        // Randomized mix of hold, presses, glitches and deferred frames.
        for (int i = 0; i < 30; i++) begin
            bus.hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                len = ($urandom_range(0, 1) == 1) ? $urandom_range(DB, 3 * DB) : $urandom_range(1, DB - 1);
                pressButton(len);
                repeat (len + 2 * DB + 6) @(negedge clk_dot);
            end
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 5));
        end
        checkOutput("pulses after random run", 32'(pulseCnt), 32'(mPulses));

        // Press edge coinciding with a dwell commit re-arms the advance.
        bus.hold = 1'b0;
        for (int i = 0; i < 4 && mDwell != DWELL - 1; i++) applyStimulus(1'b0, 0);
        checkOutput("dwell primed", 32'(mDwell), 32'(DWELL - 1));
        modeBefore = bus.mode_sel;
        pressButton(DB + 4);
        repeat (DB + 2) @(negedge clk_dot);
        applyStimulus(1'b0, 0);
        repeat (2 * DB + 6) @(negedge clk_dot);
        bus.hold = 1'b1;
        applyStimulus(1'b0, 0);
        checkOutput("press on commit survives", 32'(bus.mode_sel), 32'((modeBefore + 2) % NM));

        // Frame counter wrap.
        force dut.frameCnt_q = 16'hFFFF;
        #1;
        release dut.frameCnt_q;
        @(negedge clk_dot);
        checkOutput("frame_cnt preset", 32'(bus.frame_cnt), 32'h0000_FFFF);
        mFrames = 32'hFFFF;
        applyStimulus(1'b0, 0);
        checkOutput("frame_cnt wrap", 32'(bus.frame_cnt), 32'd0);

        // Reset while a deferred advance is waiting.
        pressButton(DB + 2);
        repeat (3 * DB + 6) @(negedge clk_dot);
        bus.vga_vsync  = 1'b1;
        bus.vga_active = 1'b1;
        @(negedge clk_dot);
        checkOutput("defer entered no pulse", 32'(bus.mode_change), 32'd0);
        repeat (2) @(negedge clk_dot);
        savedPulses = pulseCnt;
        reset = 1'b1;
        #1;
        checkOutput("mode cleared by reset", 32'(bus.mode_sel), 32'd0);
        @(negedge clk_dot);
        bus.vga_active = 1'b0;
        bus.vga_vsync  = 1'b0;
        repeat (3) begin
            @(negedge clk_dot);
            checkOutput("no pulse in reset", 32'(bus.mode_change), 32'd0);
        end
        reset  = 1'b0;
        relPos = posCnt;
        mMode = 0; mDwell = 0; mPending = 1'b0; mFrames = 0;
        readyQ.delete();
        repeat (3) @(negedge clk_dot);
        checkOutput("mode after defer reset", 32'(bus.mode_sel), 32'd0);
        checkOutput("frame_cnt after defer reset", 32'(bus.frame_cnt), 32'd0);
        checkOutput("no commit across reset", 32'(pulseCnt), 32'(savedPulses));

        bus.hold = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
        checkOutput("resume after reset", 32'(bus.mode_sel), 32'd1);
        checkOutput("lfsr long run", bus.random_num, lfsrAfter(posCnt - relPos));
        checkOutput("final pulse count", 32'(pulseCnt), 32'(mPulses));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vga_mode_sequencer.md
Name: vga_mode_sequencer

Overview:
Frame-synchronous controller that schedules the demo mode and random seed driven into vga_core, replacing the free-running-counter mode select in top. It counts frames from vga_vsync and advances the mode after a programmable dwell, or on a debounced user button press. Mode changes are committed only at a frame start while the display is blanked, so no frame ever mixes two modes. It also supplies a 32-bit LFSR random_num and a frame counter.

Parameters:
NUM_MODES, 4, number of modes cycled (2..8); mode_sel wraps at NUM_MODES-1
DWELL_FRAMES, 120, frames per mode before auto-advance (>=1)
DEBOUNCE_CYCLES, 400000, clk_dot cycles the synchronized button must be stable (>=2, <2^20)
VS_POL, 1, active level of vga_vsync

Ports:
clk_dot  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
vga_vsync  in  1  vsync from vga_core, clk_dot domain
vga_active  in  1  data-enable from vga_core
btn_next  in  1  raw asynchronous button, active-high
hold  in  1  1 = freeze auto-advance dwell count; button still works
mode_sel  out  3  current mode index
mode_bit  out  1  1 when mode_sel != 0 (drives vga_core mode_bit)
mode_change  out  1  one-cycle pulse in the cycle mode_sel updates
frame_cnt  out  16  frames since reset, wraps 0xFFFF->0x0000
random_num  out  32  Galois LFSR value

Behaviour:
- Reset (async assert, sync release): mode_sel=0, mode_bit=0, mode_change=0, frame_cnt=0, random_num=32'h0000_0001, dwell_cnt=0, btn_pending=0, debounced=0, debounce counter=0, vs_d=~VS_POL.
- frame_start: one-cycle strobe when vga_vsync==VS_POL and vs_d!=VS_POL (vs_d = vga_vsync delayed 1 clk). Combinational from vga_vsync and vs_d; it is high in the cycle vsync first shows its active level, and not again until vsync leaves and returns.
- Button path: 2-flop synchronizer -> debouncer. Counter clears whenever sync value == debounced; otherwise increments; when it reaches DEBOUNCE_CYCLES-1, debounced <= sync value, counter clears. A 0->1 transition of debounced sets btn_pending. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- State machine: RUN, DEFER.
  RUN: on frame_start, frame_cnt++. adv = btn_pending | (!hold & dwell_cnt==DWELL_FRAMES-1). If adv and vga_active==0: commit. If adv and vga_active==1: go to DEFER. If no adv: dwell_cnt++ when hold=0, unchanged when hold=1.
  DEFER: wait for the first cycle with vga_active==0, then commit and return to RUN. frame_start in DEFER still increments frame_cnt. No second advance is queued.
- Commit (one clock edge): mode_sel <= (mode_sel==NUM_MODES-1) ? 0 : mode_sel+1; dwell_cnt<=0; btn_pending<=0; mode_change=1 for exactly that cycle; mode_bit follows mode_sel in the same cycle (both registered).
- Multiple button presses before a commit collapse into one advance. A press edge in the same cycle as a commit sets btn_pending again and advances at the next frame_start.
- hold=1 with DWELL expiry pending: no auto-advance; dwell_cnt stays at its value and resumes when hold drops.
- random_num advances every clk_dot: next = {1'b0, r[31:1]} ^ (r[0] ? 32'h8020_0003 : 0). Never zero.
- Reset mid-defer or mid-debounce aborts everything; no commit occurs.
- Latency: button edge to btn_pending = 2 + DEBOUNCE_CYCLES cycles (+1 register). Commit lands on the frame_start edge in RUN with vga_active=0.

Test Plan:
- Reset release, free-run 2 clocks -> random_num 0x00000001, 0x80200003, 0xC0300002; all other outputs 0.
- NUM_MODES=3, DWELL_FRAMES=3, hold=0, 10 vsync pulses with vga_active=0 at each edge -> mode_change pulses at frames 3,6,9; mode_sel 0->1->2->0; frame_cnt=10.
- DEBOUNCE_CYCLES=8: 5-cycle btn glitch -> no advance. 20-cycle press -> btn_pending after 11 cycles; mode_sel +1 at the next frame_start only; a second press before that frame gives no extra advance.
- hold=1 across 10 frames -> mode_sel unchanged, no mode_change. Then press the button -> one advance at the next frame_start.
- Advance due while vga_active=1 at frame_start -> DEFER; commit in the first cycle vga_active=0; exactly one mode_change.
- Drive frame_cnt to 0xFFFF, then one more frame -> 0x0000. Assert reset during DEFER -> mode_sel=0, no mode_change pulse.
